// File: rtl/uart_key_rx.sv
// uart_key_rx
//   8N1 UART receiver that turns game-control keystrokes typed on a PC into
//   single-cycle key events. The serial line is synchronised, framed by a
//   small FSM with mid-bit sampling, and each correctly framed byte is
//   decoded into at most one key_pulse bit.
//
// Parameters
//   CLK_FREQ  clk frequency in Hz
//   BAUD      serial bit rate
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   uart_rx    in   serial line, idle high, asynchronous to clk
//   rx_data    out  [7:0] last correctly framed byte
//   rx_valid   out  one-cycle pulse when rx_data updates
//   frame_err  out  one-cycle pulse when the stop bit samples low
//   key_pulse  out  [5:0] one-cycle key events, valid with rx_valid:
//                   0 left(a) 1 right(d) 2 down(s) 3 up(w) 4 speed(f) 5 pause(p)
//   rx_busy    out  high whenever the FSM is not in IDLE
module uart_key_rx #(
  parameter int unsigned CLK_FREQ = 32'd50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [5:0] key_pulse,
  output logic       rx_busy
);

  localparam int unsigned CPB  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam logic [15:0] CPB_M1  = 16'(CPB - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, rx_s_q;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic [5:0]  key_q, key_d;
  logic        armed_q, armed_d;

  function automatic logic [5:0] decode_key(input logic [7:0] b);
    logic [5:0] k;
    case (b)
      8'h61, 8'h41: k = 6'b000001;
      8'h64, 8'h44: k = 6'b000010;
      8'h73, 8'h53: k = 6'b000100;
      8'h77, 8'h57: k = 6'b001000;
      8'h66, 8'h46: k = 6'b010000;
      8'h70, 8'h50: k = 6'b100000;
      default:      k = 6'b000000;
    endcase
    return k;
  endfunction

  // Synchroniser: reset to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      key_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      key_q   <= key_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    key_d   = '0;
    armed_d = armed_q;

    unique case (state_q)
      IDLE: begin
        // After reset the line may be mid-frame. Start detection is armed
        // only once the line has been seen high for a full bit time, so a
        // partial frame cannot be mistaken for a new one. Once armed it
        // stays armed, so back-to-back frames are caught on the first cycle.
        if (!armed_q) begin
          if (rx_s_q) begin
            if (timer_q == CPB_M1) begin
              armed_d = 1'b1;
              timer_d = '0;
            end else begin
              timer_d = timer_q + 16'd1;
            end
          end else begin
            timer_d = '0;
          end
        end else if (!rx_s_q) begin
          state_d = START;
          timer_d = '0;
        end
      end

      START: begin
        if (timer_q == HALF_M1) begin
          timer_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      DATA: begin
        if (timer_q == CPB_M1) begin
          timer_d = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      STOP: begin
        if (timer_q == CPB_M1) begin
          timer_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            key_d   = decode_key(shift_q);
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      BREAK: begin
        if (rx_s_q) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign key_pulse = key_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: doc/uart_key_rx.md
UART_KEY_RX -- requirements
Module: uart_key_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 32'd50_000_000, giving the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, giving the serial bit rate.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port uart_rx  input  1  serial line from PC, idle high, asynchronous to clk.
REQ-006 SHALL have port rx_data  output  8  last correctly framed byte.
REQ-007 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port key_pulse  output  6  one-cycle key events; bit0 left, 1 right, 2 down, 3 up, 4 speed_up_down, 5 pause_or_start.
REQ-010 SHALL have port rx_busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL define CPB = CLK_FREQ/BAUD (integer division) and HALF = CPB/2; a 16-bit bit-timer counts 0..CPB-1.
REQ-012 SHALL pass uart_rx through a 2-flop synchronizer; the FSM uses only the second flop (rx_s).
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: on rx_s==0 -> START, timer cleared.
REQ-015 START: when timer==HALF-1, sample rx_s; 0 -> DATA with timer and bit index cleared; 1 -> IDLE (glitch rejected, no output).
REQ-016 DATA: sample rx_s when timer==CPB-1 and clear the timer; shift LSB-first into shift register; after the 8th sample (index 7) -> STOP.
REQ-017 STOP: sample rx_s when timer==CPB-1; 1 -> load rx_data, pulse rx_valid, -> IDLE; 0 -> pulse frame_err, rx_data unchanged, -> BREAK.
REQ-018 BREAK: remain until rx_s==1, then -> IDLE; no start detection while in BREAK.
REQ-019 Decoder: in the same cycle as rx_valid, key_pulse bit asserts for byte 'a'/'A' (0x61/0x41) bit0, 'd'/'D' bit1, 's'/'S' bit2, 'w'/'W' bit3, 'f'/'F' bit4, 'p'/'P' bit5.
REQ-020 Any other byte: rx_valid pulses, key_pulse stays 0.
REQ-021 At most one key_pulse bit high in any cycle; key_pulse is 0 whenever rx_valid is 0.
REQ-022 rx_valid and frame_err SHALL never assert in the same cycle.
REQ-023 Latency: rx_valid asserts exactly one clk after the stop-bit sampling edge (registered output).
REQ-024 Back-to-back frames, with the next start bit immediately after the stop bit, SHALL all be received; IDLE must detect a start bit on the cycle after returning from STOP.
REQ-025 Timer and bit index SHALL not wrap mid-frame; bit index is 3 bits, used only in DATA.

Reset
REQ-026 While rst high: state=IDLE, both synchronizer flops=1, timer=0, bit index=0, shift register=0, rx_data=8'h00, rx_valid=0, frame_err=0, key_pulse=6'b0, rx_busy=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, the remainder of that frame produces no rx_valid unless a fresh falling edge follows with line high for at least one bit time.

Verification
REQ-028 Defaults (434 clk/bit, HALF 217): send 0x61 8N1 -> rx_data=0x61, rx_valid 1 cycle, key_pulse=6'b000001 in the same cycle.
REQ-029 Send 0x50, 0x77, 0x44 back-to-back with zero idle -> key_pulse 6'b100000, 6'b001000, 6'b000010 in order; 3 rx_valid pulses.
REQ-030 Send 0x5A ('Z') -> rx_valid=1, rx_data=0x5A, key_pulse=0.
REQ-031 Drive uart_rx low for 100 clks, then high -> START rejects it; no rx_valid, no frame_err; state back to IDLE.
REQ-032 Send 0x73 with stop bit forced low, hold line low 2000 clks, then high -> single frame_err pulse, rx_data unchanged, FSM stays in BREAK until the line goes high, then the next 0x73 decodes to key_pulse=6'b000100.
REQ-033 Assert rst during data bit 4 of 0x66 -> all outputs at reset values immediately (asynchronous); no pulse for that frame; next clean 0x66 gives key_pulse=6'b010000.
